// File: rtl/sd_rdport_arbiter.sv
// Two-requester read-port arbiter in front of a single-cycle-latency backing store.
// Round-robin between the SD emulator and host loader, with optional lock to keep ownership across a burst.
module sd_rdport_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 8
) (
    input  logic              rdclk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_lock,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_lock,
    output logic              r0_ready,
    output logic              r1_ready,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              cnt_clr,
    output logic [15:0]       r0_count,
    output logic [15:0]       r1_count
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN0     = 2'd1;
    localparam logic [1:0] OWN1     = 2'd2;

    logic [1:0]        ownState;
    logic              rrPtr;
    logic              xfer0;
    logic              xfer1;
    logic [ADDR_W-1:0] addrHold;
    logic              pend0;
    logic              pend1;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;

    // A locked owner blocks the other requester even while it is idle; rrPtr=1 favours requester 1.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (!rst) begin
            case (ownState)
                OWN0: r0_ready = r0_valid;
                OWN1: r1_ready = r1_valid;
                default: begin
                    if (r0_valid && r1_valid) begin
                        r0_ready = !rrPtr;
                        r1_ready = rrPtr;
                    end else begin
                        r0_ready = r0_valid;
                        r1_ready = r1_valid;
                    end
                end
            endcase
        end
    end

    assign xfer0    = r0_valid & r0_ready;
    assign xfer1    = r1_valid & r1_ready;
    assign mem_en   = xfer0 | xfer1;
    assign mem_addr = xfer0 ? r0_addr : (xfer1 ? r1_addr : addrHold);

    always_ff @(posedge rdclk) begin
        if (rst) begin
            ownState <= OWN_NONE;
            rrPtr    <= 1'b0;
        end else if (xfer0) begin
            ownState <= r0_lock ? OWN0 : OWN_NONE;
            rrPtr    <= 1'b1;
        end else if (xfer1) begin
            ownState <= r1_lock ? OWN1 : OWN_NONE;
            rrPtr    <= 1'b0;
        end
    end

    // Read data passes straight through from the store in the response cycle; reset kills an in-flight response.
    assign r0_rvalid = pend0 & !rst;
    assign r1_rvalid = pend1 & !rst;
    assign r0_rdata  = r0_rvalid ? mem_rdata : hold0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : hold1;

    always_ff @(posedge rdclk) begin
        if (rst) begin
            addrHold <= '0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            addrHold <= mem_addr;
            pend0    <= xfer0;
            pend1    <= xfer1;
            hold0    <= r0_rdata;
            hold1    <= r1_rdata;
        end
    end

    always_ff @(posedge rdclk) begin
        if (rst || cnt_clr) begin
            r0_count <= '0;
            r1_count <= '0;
        end else begin
            if (xfer0 && (r0_count != 16'hFFFF)) r0_count <= r0_count + 16'd1;
            if (xfer1 && (r1_count != 16'hFFFF)) r1_count <= r1_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sd_rdport_arbiter.sv
// Scoreboard bench for sd_rdport_arbiter: a queue-based ownership model predicts grants and
// pushes expected responses, which a separate monitor pops when the DUT presents rvalid.
module tb_sd_rdport_arbiter;

    logic        rdclk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [63:0] r0_addr = '0, r1_addr = '0;
    logic        r0_lock = 1'b0, r1_lock = 1'b0;
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        mem_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        cnt_clr = 1'b0;
    logic [15:0] r0_count, r1_count;

    typedef struct {
        int       id;
        int       due;
        bit [7:0] data;
    } resp_t;

    resp_t    respQ[$];
    int       cyc = 0;
    int       passCount = 0;
    int       totalCount = 0;
    int       owner = -1;
    int       lastServed = -1;
    int       cnt0 = 0, cnt1 = 0;
    bit [63:0] memAddrLast = '0;
    bit [7:0] lastData0 = '0, lastData1 = '0;

    sd_rdport_arbiter dut (
        .rdclk(rdclk), .rst(rst),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_lock(r0_lock),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_lock(r1_lock),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cnt_clr(cnt_clr), .r0_count(r0_count), .r1_count(r1_count)
    );

    always #5 rdclk = ~rdclk;

    always @(posedge rdclk) cyc <= cyc + 1;

    function automatic bit [7:0] memFn(input bit [63:0] a);
        return a[7:0] ^ a[15:8] ^ a[63:56] ^ 8'h5A;
    endfunction

    // Backing store returns garbage unless strobed, so only correctly-timed data matches.
    always @(posedge rdclk) mem_rdata <= mem_en ? memFn(mem_addr) : 8'($urandom);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input bit rs, input bit clr,
                                 input bit v0, input bit l0, input logic [63:0] a0,
                                 input bit v1, input bit l1, input logic [63:0] a1);
        rst = rs; cnt_clr = clr;
        r0_valid = v0; r0_lock = l0; r0_addr = a0;
        r1_valid = v1; r1_lock = l1; r1_addr = a1;
        @(posedge rdclk);
        #1;
    endtask

    // Reference model: decides who owns the port this cycle from the abstract ownership rules.
    always @(posedge rdclk) begin
        int        grant;
        bit [63:0] expAddr;
        #4;
        grant = -1;
        if (!rst) begin
            if (owner == 0)                   grant = r0_valid ? 0 : -1;
            else if (owner == 1)              grant = r1_valid ? 1 : -1;
            else if (r0_valid && r1_valid)    grant = (lastServed == 0) ? 1 : 0;
            else if (r0_valid)                grant = 0;
            else if (r1_valid)                grant = 1;
        end
        expAddr = (grant == 0) ? r0_addr : (grant == 1) ? r1_addr : memAddrLast;
        if (cyc >= 2) begin
            checkOutput("r0_ready", 64'(r0_ready), 64'(grant == 0));
            checkOutput("r1_ready", 64'(r1_ready), 64'(grant == 1));
            checkOutput("mem_en", 64'(mem_en), 64'(grant >= 0));
            checkOutput("mem_addr", mem_addr, expAddr);
            checkOutput("r0_count", 64'(r0_count), 64'(cnt0));
            checkOutput("r1_count", 64'(r1_count), 64'(cnt1));
        end
        if (rst) begin
            while (respQ.size() > 0 && respQ[0].due == cyc) void'(respQ.pop_front());
            owner = -1; lastServed = -1; cnt0 = 0; cnt1 = 0; memAddrLast = '0;
        end else begin
            if (grant >= 0) begin
                respQ.push_back('{id: grant, due: cyc + 1, data: memFn(expAddr)});
                memAddrLast = expAddr;
                if (grant == 0) cnt0 = (cnt0 < 65535) ? cnt0 + 1 : 65535;
                else            cnt1 = (cnt1 < 65535) ? cnt1 + 1 : 65535;
                owner = ((grant == 0) ? r0_lock : r1_lock) ? grant : -1;
                lastServed = grant;
            end
            if (cnt_clr) begin
                cnt0 = 0; cnt1 = 0;
            end
        end
    end

    // Monitor: pops the scoreboard when a response is due and checks held data otherwise.
    always @(posedge rdclk) begin
        resp_t e;
        #7;
        if (cyc >= 2) begin
            if (respQ.size() > 0 && respQ[0].due == cyc) begin
                e = respQ.pop_front();
                checkOutput("r0_rvalid", 64'(r0_rvalid), 64'(e.id == 0));
                checkOutput("r1_rvalid", 64'(r1_rvalid), 64'(e.id == 1));
                if (e.id == 0) begin
                    checkOutput("r0_rdata", 64'(r0_rdata), 64'(e.data));
                    lastData0 = e.data;
                end else begin
                    checkOutput("r1_rdata", 64'(r1_rdata), 64'(e.data));
                    lastData1 = e.data;
                end
            end else begin
                checkOutput("r0_rvalid_idle", 64'(r0_rvalid), 64'd0);
                checkOutput("r1_rvalid_idle", 64'(r1_rvalid), 64'd0);
                checkOutput("r0_rdata_hold", 64'(r0_rdata), 64'(lastData0));
                checkOutput("r1_rdata_hold", 64'(r1_rdata), 64'(lastData1));
            end
        end
        if (rst) begin
            lastData0 = '0; lastData1 = '0;
        end
    end

    initial begin
        #1;
        repeat (3) applyStimulus(1, 0, 0, 0, '0, 0, 0, '0);
        // Single requester at 0x105, then an idle cycle for the response.
        applyStimulus(0, 0, 1, 0, 64'h105, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0, 0, 0, '0);
        // Contention: both valid for 10 cycles, no lock.
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 1, 0, 64'h1000 + 64'(i), 1, 0, 64'h2000 + 64'(i));
        applyStimulus(0, 1, 0, 0, '0, 0, 0, '0);
        // Lock burst by r1 while r0 keeps asking.
        applyStimulus(0, 0, 0, 0, '0, 1, 1, 64'h3000);
        for (int i = 1; i < 4; i++)
            applyStimulus(0, 0, 1, 0, 64'h4000, 1, (i < 3), 64'h3000 + 64'(i));
        applyStimulus(0, 0, 1, 0, 64'h4000, 0, 0, '0);
        // Owner r0 locks and then idles while r1 waits.
        applyStimulus(0, 0, 1, 1, 64'h5000, 0, 0, '0);
        repeat (3) applyStimulus(0, 0, 0, 0, '0, 1, 0, 64'h6000);
        applyStimulus(0, 0, 1, 0, 64'h5001, 1, 0, 64'h6000);
        applyStimulus(0, 0, 0, 0, '0, 1, 0, 64'h6000);
        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 2000; i++)
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        // Reset right after a locked r1 transfer, then contention must favour r0.
        applyStimulus(0, 0, 0, 0, '0, 1, 1, 64'h7000);
        applyStimulus(1, 0, 1, 0, 64'h8000, 1, 1, 64'h7001);
        applyStimulus(0, 0, 1, 0, 64'h8000, 1, 0, 64'h7002);
        applyStimulus(0, 0, 0, 0, '0, 1, 0, 64'h7002);
        // Drive r0 past counter saturation, then clear alongside a transfer.
        applyStimulus(1, 0, 0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 65537; i++)
            applyStimulus(0, 0, 1, 0, 64'(i), 0, 0, '0);
        applyStimulus(0, 1, 1, 0, 64'h9000, 0, 0, '0);
        repeat (3) applyStimulus(0, 0, 0, 0, '0, 0, 0, '0);
        checkOutput("scoreboard_empty", 64'(respQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/sd_rdport_arbiter.md
SD_RDPORT_ARBITER -- requirements
Module: sd_rdport_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the width of the byte address on every port.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the width of read data on every port.
REQ-003 The block SHALL have port rdclk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports r0_valid and r1_valid, input, 1 bit each: read request from requester 0 (SD emulator) and requester 1 (host loader/debug).
REQ-006 The block SHALL have ports r0_addr and r1_addr, input, ADDR_W each: the requested byte address.
REQ-007 The block SHALL have ports r0_lock and r1_lock, input, 1 bit each: the requester is asking to keep ownership after this transfer.
REQ-008 The block SHALL have ports r0_ready and r1_ready, output, 1 bit each: the request is accepted this cycle.
REQ-009 The block SHALL have ports r0_rvalid and r1_rvalid, output, 1 bit each: read data is valid for that requester.
REQ-010 The block SHALL have ports r0_rdata and r1_rdata, output, DATA_W each: the returned read data.
REQ-011 The block SHALL have port mem_en, output, 1 bit: read strobe to the backing store.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W: address to the backing store.
REQ-013 The block SHALL have port mem_rdata, input, DATA_W: backing-store data, valid exactly 1 cycle after mem_en.
REQ-014 The block SHALL have port cnt_clr, input, 1 bit: clears both transfer counters.
REQ-015 The block SHALL have ports r0_count and r1_count, output, 16 bits each: accepted-transfer counters.

Function
REQ-016 A transfer for requester i SHALL occur in a cycle where ri_valid=1 and ri_ready=1; at most one transfer SHALL occur per cycle.
REQ-017 Ownership state SHALL be one of OWN_NONE, OWN0, OWN1.
REQ-018 In OWN_NONE, with one requester valid, that requester SHALL get ready the same cycle (combinational grant, 0-cycle acceptance latency).
REQ-019 In OWN_NONE, with both requesters valid, the requester not served by the most recent transfer SHALL be granted; after reset, requester 0 SHALL win.
REQ-020 In OWNi, only requester i SHALL be able to receive ready; the other requester's ready SHALL be 0 even if requester i is idle.
REQ-021 A transfer by i with ri_lock=1 SHALL move the state to OWNi; a transfer by i with ri_lock=0 SHALL move it to OWN_NONE.
REQ-022 With no transfer, the state SHALL be unchanged.
REQ-023 After every transfer, the round-robin pointer SHALL favour the other requester.
REQ-024 On a transfer, mem_en SHALL be 1 and mem_addr SHALL equal the granted ri_addr in that same cycle; otherwise mem_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-025 Exactly one cycle after a transfer by i, ri_rvalid SHALL be 1 and ri_rdata SHALL equal mem_rdata; the other requester's rvalid SHALL be 0.
REQ-026 rdata SHALL hold its value when rvalid=0.
REQ-027 Back-to-back transfers SHALL be sustained at 1 per cycle, with no bubble and no lost response.
REQ-028 On a transfer, ri_count SHALL increment by 1 and saturate at 0xFFFF.
REQ-029 cnt_clr=1 SHALL zero both counters next cycle and SHALL take precedence over a simultaneous increment.

Reset
REQ-030 While rst=1, at the next edge all ready, rvalid, and mem_en SHALL be 0; rdata, mem_addr, and counters SHALL be 0; state SHALL be OWN_NONE; the pointer SHALL favour requester 0.
REQ-031 A reset asserted in the cycle after a transfer SHALL suppress that transfer's rvalid.
REQ-032 A reset asserted during OWNi SHALL release the lock.
REQ-033 During rst=1, ready SHALL be 0, so no transfer occurs.

Verification
REQ-034 Single requester: r0 presents addr 0x105, lock=0 -> r0_ready=1 the same cycle; mem_addr=0x105; next cycle r0_rvalid=1 with r0_rdata=mem_rdata; r0_count=1.
REQ-035 Contention after reset: both valid -> r0 served first, r1 next cycle, then alternating; counts equal after 10 cycles (5/5).
REQ-036 Lock burst: r1 sends 4 transfers, lock=1 on the first 3, while r0 stays valid -> r0_ready=0 for all 4, then r0 is granted the cycle after r1's unlocked transfer.
REQ-037 Lock with idle owner: r0 locks, then drops valid for 3 cycles while r1 is valid -> r1_ready stays 0 for all 3 cycles.
REQ-038 Saturation and clear: force 65537 r0 transfers -> r0_count=0xFFFF; cnt_clr with a simultaneous transfer -> count=0.
REQ-039 Mid-burst reset: rst during OWN1 right after a transfer -> no r1_rvalid; after reset both valid -> r0 granted.
